// File: rtl/float_sub_seq.sv
// float_sub_seq: multi-cycle |a|-|b| subtractor for 8-bit minifloat {sign,exp,mant}.
// Ports: clk, rst_n, in_valid/in_ready, a, b, out_valid/out_ready, out_data, underflow.
module float_sub_seq #(
    parameter int EXP_W = 3,
    parameter int MAN_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_data,
    output logic                   underflow
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ALIGN = 3'd1;
    localparam logic [2:0] SUB   = 3'd2;
    localparam logic [2:0] NORM  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [SW-1:0]    sa_q, sa_d;
    logic [SW-1:0]    sb_q, sb_d;
    logic [SW-1:0]    s_q, s_d;
    logic [EXP_W-1:0] e_q, e_d;
    logic [EXP_W-1:0] cnt_q, cnt_d;
    logic             shift_a_q, shift_a_d;
    logic             sign_q, sign_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic             underflow_q, underflow_d;
    logic             out_valid_q, out_valid_d;

    logic [EXP_W-1:0] ea, eb;
    logic             unused_signs;

    // Input signs are ignored: only magnitudes take part.
    assign unused_signs = a[W-1] ^ b[W-1];
    assign ea = a[W-2:MAN_W];
    assign eb = b[W-2:MAN_W];

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign underflow = underflow_q;

    always_comb begin
        state_d     = state_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        s_d         = s_q;
        e_d         = e_q;
        cnt_d       = cnt_q;
        shift_a_d   = shift_a_q;
        sign_d      = sign_q;
        out_data_d  = out_data_q;
        underflow_d = underflow_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sa_d = {|ea, a[MAN_W-1:0]};
                    sb_d = {|eb, b[MAN_W-1:0]};
                    if (ea >= eb) begin
                        e_d       = ea;
                        cnt_d     = ea - eb;
                        shift_a_d = 1'b0;
                    end else begin
                        e_d       = eb;
                        cnt_d     = eb - ea;
                        shift_a_d = 1'b1;
                    end
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                if (cnt_q != '0) begin
                    // Truncating alignment of the smaller-exponent operand.
                    if (shift_a_q) sa_d = sa_q >> 1;
                    else           sb_d = sb_q >> 1;
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = SUB;
                end
            end
            SUB: begin
                if (sa_q >= sb_q) begin
                    s_d    = sa_q - sb_q;
                    sign_d = 1'b0;
                end else begin
                    s_d    = sb_q - sa_q;
                    sign_d = 1'b1;
                end
                state_d = NORM;
            end
            NORM: begin
                if (s_q == '0) begin
                    out_data_d  = '0;
                    underflow_d = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (s_q[SW-1]) begin
                    out_data_d  = {sign_q, e_q, s_q[MAN_W-1:0]};
                    underflow_d = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (e_q <= EXP_W'(1)) begin
                    // Cannot normalise further: emit with exp code 0.
                    out_data_d  = {sign_q, {EXP_W{1'b0}}, s_q[MAN_W-1:0]};
                    underflow_d = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    s_d = s_q << 1;
                    e_d = e_q - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sa_q        <= '0;
            sb_q        <= '0;
            s_q         <= '0;
            e_q         <= '0;
            cnt_q       <= '0;
            shift_a_q   <= 1'b0;
            sign_q      <= 1'b0;
            out_data_q  <= '0;
            underflow_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            s_q         <= s_d;
            e_q         <= e_d;
            cnt_q       <= cnt_d;
            shift_a_q   <= shift_a_d;
            sign_q      <= sign_d;
            out_data_q  <= out_data_d;
            underflow_q <= underflow_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule
